// File: rtl/wb_arbiter.sv
// Register-file write-port owner: merges ALU and load results through an in-order FIFO
// into one write per cycle and keeps a per-register pending-write scoreboard.
// Optional write-back forwarding to decode is enabled by defining WB_FORWARD_EN.
module wb_arbiter #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid,
   output logic                     alu_ready,
   input  logic [ADDRESS_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0]    alu_data,
   input  logic                     mem_valid,
   output logic                     mem_ready,
   input  logic [ADDRESS_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0]    mem_data,
   input  logic                     issue_valid,
   input  logic [ADDRESS_WIDTH-1:0] issue_rd,
   output logic                     issue_ready,
   input  logic [ADDRESS_WIDTH-1:0] query_rs1,
   input  logic [ADDRESS_WIDTH-1:0] query_rs2,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic [ADDRESS_WIDTH-1:0] AD3,
   output logic [DATA_WIDTH-1:0]    WD3,
   output logic                     WE3,
   output logic [$clog2(DEPTH):0]   count
`ifdef WB_FORWARD_EN
   ,
   output logic [DATA_WIDTH-1:0]    rs1_fwd,
   output logic [DATA_WIDTH-1:0]    rs2_fwd
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int SUM_W  = CNT_W + 1;
   localparam int NREG   = 1 << ADDRESS_WIDTH;
   localparam int PEND_W = 3;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [ADDRESS_WIDTH-1:0] fifo_rd   [DEPTH];
   logic [DATA_WIDTH-1:0]    fifo_data [DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         alu_slot;

   logic mem_fire_p0;
   logic alu_fire_p0;
   logic mem_push_p0;
   logic alu_push_p0;
   logic pop_p0;

   logic [PEND_W-1:0] pending [NREG];
   logic [NREG-1:0]   pend_inc;
   logic [NREG-1:0]   pend_dec;
   logic              issue_fire;

   // ---- stage p0: producer handshake and FIFO write ----
   always_comb begin
      mem_ready = (count < CNT_W'(DEPTH));
      alu_ready = ((SUM_W'(count) + SUM_W'(mem_valid & mem_ready)) < SUM_W'(DEPTH));
   end

   // rd = 0 results complete the handshake but are never stored
   assign mem_fire_p0 = mem_valid & mem_ready;
   assign alu_fire_p0 = alu_valid & alu_ready;
   assign mem_push_p0 = mem_fire_p0 & (mem_rd != '0);
   assign alu_push_p0 = alu_fire_p0 & (alu_rd != '0);
   assign pop_p0      = (count != '0);
   assign alu_slot    = wr_ptr + PTR_W'(mem_push_p0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(mem_push_p0) + PTR_W'(alu_push_p0);
         rd_ptr <= rd_ptr + PTR_W'(pop_p0);
         count  <= count + CNT_W'(mem_push_p0) + CNT_W'(alu_push_p0) - CNT_W'(pop_p0);
      end
   end

   // The load result takes the lower slot so it drains ahead of a same-edge ALU result.
   always_ff @(posedge clk) begin
      if (mem_push_p0) begin
         fifo_rd[wr_ptr]   <= mem_rd;
         fifo_data[wr_ptr] <= mem_data;
      end
      if (alu_push_p0) begin
         fifo_rd[alu_slot]   <= alu_rd;
         fifo_data[alu_slot] <= alu_data;
      end
   end

   // ---- stage p1: register-file write port ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WE3 <= 1'b0;
         AD3 <= '0;
         WD3 <= '0;
      end else if (pop_p0) begin
         WE3 <= 1'b1;
         AD3 <= fifo_rd[rd_ptr];
         WD3 <= fifo_data[rd_ptr];
      end else begin
         WE3 <= 1'b0;
      end
   end

   // ---- scoreboard: pending writes per architectural register ----
   assign issue_ready = (pending[issue_rd] != PEND_MAX);
   assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

   always_comb begin
      pend_inc = '0;
      pend_dec = '0;
      if (issue_fire) pend_inc[issue_rd] = 1'b1;
      if (WE3)        pend_dec[AD3]      = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) pending[i] <= '0;
      end else begin
         for (int i = 1; i < NREG; i++) begin
            if (pend_inc[i] && !pend_dec[i])
               pending[i] <= pending[i] + PEND_W'(1);
            else if (pend_dec[i] && !pend_inc[i] && (pending[i] != '0))
               pending[i] <= pending[i] - PEND_W'(1);
         end
      end
   end

`ifdef WB_FORWARD_EN
   logic fwd1_hit;
   logic fwd2_hit;

   // The last outstanding write is on the port this cycle, so decode may take it directly.
   always_comb begin
      fwd1_hit = WE3 && (AD3 == query_rs1) && (pending[query_rs1] == PEND_W'(1));
      fwd2_hit = WE3 && (AD3 == query_rs2) && (pending[query_rs2] == PEND_W'(1));
      rs1_busy = (pending[query_rs1] != '0) && !fwd1_hit;
      rs2_busy = (pending[query_rs2] != '0) && !fwd2_hit;
      rs1_fwd  = fwd1_hit ? WD3 : '0;
      rs2_fwd  = fwd2_hit ? WD3 : '0;
   end
`else
   always_comb begin
      rs1_busy = (pending[query_rs1] != '0);
      rs2_busy = (pending[query_rs2] != '0);
   end
`endif

   assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_W'(DEPTH));
   assert property (@(posedge clk) disable iff (!rst_n) WE3 |-> (AD3 != '0));

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, scoreboard/forwarding sequences,
// randomized traffic against a queue-based reference model, and asynchronous reset checks.
module tb_wb_arbiter;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          alu_valid, alu_ready, mem_valid, mem_ready;
   logic [AW-1:0] alu_rd, mem_rd, issue_rd, query_rs1, query_rs2, AD3;
   logic [DW-1:0] alu_data, mem_data, WD3;
   logic          issue_valid, issue_ready, rs1_busy, rs2_busy, WE3;
   logic [CW-1:0] count;
`ifdef WB_FORWARD_EN
   logic [DW-1:0] rs1_fwd, rs2_fwd;
`endif

   always #5 clk = ~clk;

   wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
      .query_rs1(query_rs1), .query_rs2(query_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .AD3(AD3), .WD3(WD3), .WE3(WE3), .count(count)
`ifdef WB_FORWARD_EN
      , .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
`endif
   );

   int n_run  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      issue_valid = 1'b0; issue_rd = '0;
      query_rs1 = '0; query_rs2 = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      #13;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          mq[$];
   int            pend[32];
   logic          m_we;
   logic [AW-1:0] m_ad;
   logic [DW-1:0] m_wd;
   bit            last_ar, last_mr;

   task automatic model_reset();
      mq.delete();
      for (int r = 0; r < 32; r++) pend[r] = 0;
      m_we = 1'b0; m_ad = '0; m_wd = '0;
      last_ar = 1'b1; last_mr = 1'b1;
   endtask

   function automatic logic exp_busy(input logic [AW-1:0] q);
`ifdef WB_FORWARD_EN
      if (m_we && m_ad == q && pend[q] == 1) return 1'b0;
`endif
      return (pend[q] != 0);
   endfunction

   function automatic logic [DW-1:0] exp_fwd(input logic [AW-1:0] q);
      if (m_we && m_ad == q && pend[q] == 1) return m_wd;
      return '0;
   endfunction

   task automatic check_all(input string tag);
      logic emr, ear, eir;
      emr = (mq.size() < DEPTH);
      ear = ((mq.size() + ((mem_valid && emr) ? 1 : 0)) < DEPTH);
      eir = (pend[issue_rd] != 7);
      chk({tag, " count"}, 32'(count), 32'(mq.size()));
      chk({tag, " WE3"}, 32'(WE3), 32'(m_we));
      chk({tag, " AD3"}, 32'(AD3), 32'(m_ad));
      chk({tag, " WD3"}, WD3, m_wd);
      chk({tag, " mem_ready"}, 32'(mem_ready), 32'(emr));
      chk({tag, " alu_ready"}, 32'(alu_ready), 32'(ear));
      chk({tag, " issue_ready"}, 32'(issue_ready), 32'(eir));
      chk({tag, " rs1_busy"}, 32'(rs1_busy), 32'(exp_busy(query_rs1)));
      chk({tag, " rs2_busy"}, 32'(rs2_busy), 32'(exp_busy(query_rs2)));
`ifdef WB_FORWARD_EN
      chk({tag, " rs1_fwd"}, rs1_fwd, exp_fwd(query_rs1));
      chk({tag, " rs2_fwd"}, rs2_fwd, exp_fwd(query_rs2));
`endif
   endtask

   // Advances the model across one clock edge using the inputs currently applied.
   task automatic model_edge();
      bit   emr, ear, eir;
      ent_t e;
      emr = (mq.size() < DEPTH);
      ear = ((mq.size() + ((mem_valid && emr) ? 1 : 0)) < DEPTH);
      eir = (pend[issue_rd] != 7);
      last_ar = ear;
      last_mr = emr;
      for (int r = 1; r < 32; r++) begin
         int nv;
         nv = pend[r] + ((issue_valid && eir && issue_rd == AW'(r)) ? 1 : 0)
                      - ((m_we && m_ad == AW'(r)) ? 1 : 0);
         pend[r] = (nv < 0) ? 0 : nv;
      end
      if (mq.size() > 0) begin
         e = mq.pop_front();
         m_we = 1'b1; m_ad = e.rd; m_wd = e.data;
      end else begin
         m_we = 1'b0;
      end
      if (mem_valid && emr && mem_rd != '0) mq.push_back('{mem_rd, mem_data});
      if (alu_valid && ear && alu_rd != '0) mq.push_back('{alu_rd, alu_data});
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [31:0] av, ard, ad, mv, mrd, md;
      logic [31:0] e_ar, e_mr, e_we, e_ad, e_wd, e_cnt;
   } vec_t;

   localparam int NV = 16;
   vec_t vt[NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{1, 5, 'hDEADBEEF, 0, 0, 0,    1, 1, 0, 0, 0, 1};
      vt[1]  = '{0, 0, 0, 0, 0, 0,             1, 1, 1, 5, 'hDEADBEEF, 0};
      vt[2]  = '{1, 4, 'h22, 1, 3, 'h11,       1, 1, 0, 5, 'hDEADBEEF, 2};
      vt[3]  = '{0, 0, 0, 0, 0, 0,             1, 1, 1, 3, 'h11, 1};
      vt[4]  = '{0, 0, 0, 0, 0, 0,             1, 1, 1, 4, 'h22, 0};
      vt[5]  = '{0, 0, 0, 0, 0, 0,             1, 1, 0, 4, 'h22, 0};
      vt[6]  = '{1, 0, 'hFFFF, 0, 0, 0,        1, 1, 0, 4, 'h22, 0};
      vt[7]  = '{0, 0, 0, 0, 0, 0,             1, 1, 0, 4, 'h22, 0};
      vt[8]  = '{1, 2, 'hA2, 1, 1, 'hA1,       1, 1, 0, 4, 'h22, 2};
      vt[9]  = '{1, 4, 'hA4, 1, 3, 'hA3,       1, 1, 1, 1, 'hA1, 3};
      vt[10] = '{1, 6, 'hA6, 1, 5, 'hA5,       0, 1, 1, 2, 'hA2, 3};
      vt[11] = '{1, 6, 'hA6, 0, 0, 0,          1, 1, 1, 3, 'hA3, 3};
      vt[12] = '{0, 0, 0, 0, 0, 0,             1, 1, 1, 4, 'hA4, 2};
      vt[13] = '{0, 0, 0, 0, 0, 0,             1, 1, 1, 5, 'hA5, 1};
      vt[14] = '{0, 0, 0, 0, 0, 0,             1, 1, 1, 6, 'hA6, 0};
      vt[15] = '{0, 0, 0, 0, 0, 0,             1, 1, 0, 6, 'hA6, 0};

      // asynchronous reset before any clock edge
      idle_inputs();
      #1 rst_n = 1'b0;
      #3;
      chk("reset WE3", 32'(WE3), 0);
      chk("reset AD3", 32'(AD3), 0);
      chk("reset WD3", WD3, 0);
      chk("reset count", 32'(count), 0);
      chk("reset alu_ready", 32'(alu_ready), 1);
      chk("reset mem_ready", 32'(mem_ready), 1);
      chk("reset issue_ready", 32'(issue_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < NV; i++) begin
         alu_valid = vt[i].av[0];  alu_rd = vt[i].ard[AW-1:0];  alu_data = vt[i].ad;
         mem_valid = vt[i].mv[0];  mem_rd = vt[i].mrd[AW-1:0];  mem_data = vt[i].md;
         #1;
         chk($sformatf("vec%0d alu_ready", i), 32'(alu_ready), vt[i].e_ar);
         chk($sformatf("vec%0d mem_ready", i), 32'(mem_ready), vt[i].e_mr);
         tick();
         chk($sformatf("vec%0d WE3", i), 32'(WE3), vt[i].e_we);
         chk($sformatf("vec%0d AD3", i), 32'(AD3), vt[i].e_ad);
         chk($sformatf("vec%0d WD3", i), WD3, vt[i].e_wd);
         chk($sformatf("vec%0d count", i), 32'(count), vt[i].e_cnt);
      end
      idle_inputs();

      // scoreboard saturation on x7
      query_rs1 = 7;
      query_rs2 = 0;
      for (int k = 0; k < 8; k++) begin
         issue_valid = 1'b1; issue_rd = 7;
         #1;
         chk($sformatf("sat issue_ready #%0d", k), 32'(issue_ready), (k < 7) ? 1 : 0);
         tick();
      end
      issue_valid = 1'b0;
      #1;
      chk("sat issue_ready held", 32'(issue_ready), 0);
      chk("sat rs1_busy", 32'(rs1_busy), 1);
      chk("x0 never busy", 32'(rs2_busy), 0);

      alu_valid = 1'b1; alu_rd = 7; alu_data = 'h70;
      tick();
      alu_valid = 1'b0;
      tick();
      chk("commit x7 WE3", 32'(WE3), 1);
      chk("commit x7 AD3", 32'(AD3), 7);
      chk("pending 7 before decrement", 32'(issue_ready), 0);
      tick();
      chk("pending 6 after decrement", 32'(issue_ready), 1);

      // issue and commit of x7 on the same edge
      alu_valid = 1'b1; alu_rd = 7; alu_data = 'h71;
      tick();
      alu_valid = 1'b0;
      tick();
      issue_valid = 1'b1; issue_rd = 7;
      #1;
      chk("same-edge WE3", 32'(WE3), 1);
      chk("same-edge issue_ready", 32'(issue_ready), 1);
      tick();
      issue_valid = 1'b0;
      #1;
      chk("same-edge unchanged (6)", 32'(issue_ready), 1);
      issue_valid = 1'b1;
      tick();
      issue_valid = 1'b0;
      #1;
      chk("back to 7", 32'(issue_ready), 0);

      // drain the seven outstanding x7 writes
      for (int k = 0; k < 7; k++) begin
         alu_valid = 1'b1; alu_rd = 7; alu_data = 32'(k);
         tick();
         alu_valid = 1'b0;
         tick();
         tick();
         chk($sformatf("drain x7 rs1_busy #%0d", k), 32'(rs1_busy), (k < 6) ? 1 : 0);
      end

      // forwarding window on x9
      issue_valid = 1'b1; issue_rd = 9;
      tick();
      issue_valid = 1'b0;
      query_rs1 = 9; query_rs2 = 9;
      #1;
      chk("x9 busy after issue", 32'(rs1_busy), 1);
      alu_valid = 1'b1; alu_rd = 9; alu_data = 'hA5A5A5A5;
      tick();
      alu_valid = 1'b0;
      tick();
      chk("x9 WE3", 32'(WE3), 1);
      chk("x9 AD3", 32'(AD3), 9);
`ifdef WB_FORWARD_EN
      chk("x9 rs1_busy fwd", 32'(rs1_busy), 0);
      chk("x9 rs1_fwd", rs1_fwd, 'hA5A5A5A5);
      chk("x9 rs2_fwd", rs2_fwd, 'hA5A5A5A5);
`else
      chk("x9 rs1_busy until decrement", 32'(rs1_busy), 1);
`endif
      tick();
      chk("x9 rs1_busy cleared", 32'(rs1_busy), 0);
`ifdef WB_FORWARD_EN
      chk("x9 rs1_fwd cleared", rs1_fwd, 0);
`endif

      // randomized traffic against the reference model
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (!(alu_valid && !last_ar)) begin
            alu_valid = ($urandom_range(0, 9) < 7);
            alu_rd    = AW'($urandom_range(0, 7));
            alu_data  = $urandom;
         end
         if (!(mem_valid && !last_mr)) begin
            mem_valid = ($urandom_range(0, 9) < 5);
            mem_rd    = AW'($urandom_range(0, 7));
            mem_data  = $urandom;
         end
         issue_valid = ($urandom_range(0, 9) < 4);
         issue_rd    = AW'($urandom_range(0, 7));
         query_rs1   = AW'($urandom_range(0, 7));
         query_rs2   = AW'($urandom_range(0, 7));
         #1;
         check_all($sformatf("rnd%0d", cyc));
         model_edge();
         tick();
      end

      // asynchronous reset in the middle of a burst
      do_reset();
      alu_valid = 1'b1; alu_rd = 1; alu_data = 'hB1;
      mem_valid = 1'b1; mem_rd = 2; mem_data = 'hB2;
      tick();
      tick();
      chk("burst WE3", 32'(WE3), 1);
      chk("burst AD3", 32'(AD3), 2);
      chk("burst count", 32'(count), 3);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset WE3", 32'(WE3), 0);
      chk("midreset count", 32'(count), 0);
      chk("midreset AD3", 32'(AD3), 0);
      chk("midreset WD3", WD3, 0);
      chk("midreset alu_ready", 32'(alu_ready), 1);
      chk("midreset mem_ready", 32'(mem_ready), 1);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      chk("post-reset no write", 32'(WE3), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port owner for the RISC-V core. Accepts completed results from the single-cycle ALU path and the variable-latency load path over valid/ready, queues them in a small in-order FIFO, and drives the register file's single write port (address, data, enable) at one write per cycle. Also keeps a per-register pending-write scoreboard so decode can stall on registers with writes still in flight.

## Interface
- ADDRESS_WIDTH, 5: register address width.
- DATA_WIDTH, 32: result width.
- DEPTH, 4: FIFO entries; power of two, ≥2.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid / alu_ready  in / out  1  ALU result handshake.
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid / mem_ready  in / out  1  load result handshake.
- mem_rd  in  ADDRESS_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load result.
- issue_valid  in  1  decode issues an instruction writing issue_rd.
- issue_rd  in  ADDRESS_WIDTH  destination of issued instruction.
- issue_ready  out  1  low when pending[issue_rd] saturated.
- query_rs1, query_rs2  in  ADDRESS_WIDTH  decode source registers.
- rs1_busy, rs2_busy  out  1  source has a write pending.
- AD3  out  ADDRESS_WIDTH  write address to register file.
- WD3  out  DATA_WIDTH  write data to register file.
- WE3  out  1  write enable to register file.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- rs1_fwd, rs2_fwd  out  DATA_WIDTH  only with WB_FORWARD_EN.

## Operation
- Push: a transfer occurs on an edge with valid & ready. mem_ready = (count < DEPTH). alu_ready = (count + (mem_valid & mem_ready) < DEPTH). Both accepted in one edge: mem entry is stored ahead of the ALU entry.
- rd = 0 results: handshake completes normally (ready is computed as above), but no entry is stored and no write is issued.
- Pop: on each edge with count > 0, the head moves into the output register (AD3/WD3 loaded, WE3 = 1). With count = 0, WE3 = 0 and AD3/WD3 hold their values.
- Simultaneous push(0–2) and pop(0–1) on one edge: count_next = count + pushes − pop. This never exceeds DEPTH because ready accounts for the current count only.
- Scoreboard: a 3-bit pending counter per register, x1–x31. Increment on issue_valid & issue_ready with issue_rd ≠ 0. Decrement on any edge with WE3 = 1, for register AD3. Increment and decrement of the same register on one edge leave the counter unchanged.
- issue_ready = (pending[issue_rd] ≠ 7).
- rsN_busy = (pending[query_rsN] ≠ 0). x0 is never busy.
- Producer stall: the producer holds rd/data stable while valid & !ready.

## Timing
- Reset, asynchronous: FIFO emptied, count = 0, WE3 = 0, AD3 = 0, WD3 = 0, all pending = 0. In-flight entries are discarded and no write is issued. alu_ready, mem_ready and issue_ready are 1 after reset.
- Latency with an empty FIFO: a result accepted at edge k gives WE3 = 1 after edge k+1. The register file writes at edge k+2, and the pending counter decrements at edge k+2.
- Throughput: one write per cycle. Sustained dual-producer input back-pressures the ALU path once the FIFO is full.
- The busy outputs, readys and issue_ready are combinational from registered state and query/valid inputs. WE3, AD3 and WD3 are registered.

## Configuration
- WB_FORWARD_EN defined: rs1_fwd and rs2_fwd ports exist. When WE3 & AD3 = query_rsN & pending[query_rsN] = 1, rsN_busy reads 0 and rsN_fwd = WD3. Otherwise rsN_fwd = 0.
- WB_FORWARD_EN not defined: the fwd ports are absent, and busy stays asserted until the decrement edge.

## Test plan
- Reset, then ALU push of rd = 5, data = 0xDEADBEEF at edge 1 -> WE3 = 1, AD3 = 5, WD3 = 0xDEADBEEF after edge 2; count returns to 0.
- Both producers valid on one edge, mem rd = 3 / 0x11, ALU rd = 4 / 0x22 -> writes appear in consecutive cycles: x3 = 0x11, then x4 = 0x22.
- Fill the FIFO with DEPTH = 4 while the output is busy -> mem_ready = 0 and alu_ready = 0 at count = 4; with count = 3 and both valid, mem accepted and alu_ready = 0.
- ALU push with rd = 0, data = 0xFFFF -> handshake completes, count unchanged, WE3 stays 0.
- Issue rd = 7 eight times with no writes -> issue_ready = 0 at pending = 7. Issue and commit of x7 on the same edge -> counter unchanged. rs1_busy = 1 for query_rs1 = 7 until the final commit.
- With WB_FORWARD_EN, pending[9] = 1 and WE3 = 1, AD3 = 9, WD3 = 0xA5A5A5A5 -> rs1_busy = 0, rs1_fwd = 0xA5A5A5A5. Assert rst_n low mid-burst -> WE3 = 0 immediately and count = 0.
